// File: rtl/shift_add_mul8.sv
// Sequential unsigned shift-and-add multiplier: WIDTH iterations, then one FIN cycle
// so the downstream register (which captures while done is low) sees the final product.
module shift_add_mul8 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   product,
   output logic                 done,
   output logic                 busy
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFin, StDone} state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [PW-1:0]     product_q, product_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      product_d = product_q;
      done_d    = done_q;
      busy_d    = busy_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               mcand_d   = {{WIDTH{1'b0}}, a};
               mplier_d  = b;
               product_d = '0;
               count_d   = '0;
               done_d    = 1'b0;
               busy_d    = 1'b1;
               state_d   = StCalc;
            end
         end
         StCalc: begin
            // Carry-out cannot occur: the product of two WIDTH-bit values fits in PW bits.
            if (mplier_q[0]) begin
               product_d = product_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            if (count_q == CntW'(WIDTH - 1)) begin
               state_d = StFin;
            end
         end
         StFin: begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         product_q <= '0;
         done_q    <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
         product_q <= product_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign product = product_q;
   assign done    = done_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_shift_add_mul8.sv
// Randomized self-checking bench for shift_add_mul8 against an arithmetic reference
// (partial product after k steps equals a * (b mod 2^k)).
module tb_shift_add_mul8;

   localparam int unsigned WIDTH = 8;

   logic               clk;
   logic               rst;
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [2*WIDTH-1:0] product;
   logic               done;
   logic               busy;
   logic [2*WIDTH-1:0] ds_reg;

   int n_checks = 0;
   int n_pass   = 0;

   shift_add_mul8 #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .product (product),
      .done    (done),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream result register: captures every edge while done is low.
   always @(posedge clk or negedge rst) begin
      if (!rst) ds_reg <= '0;
      else if (!done) ds_reg <= product;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Inputs are driven by the caller between edges; returns 1 time unit after E9.
   task automatic run_mul(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input bit ign_start);
      int unsigned full;
      int unsigned part;
      full  = int'(av) * int'(bv);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      check("e0_done", 32'(done), 32'd0);
      check("e0_busy", 32'(busy), 32'd1);
      check("e0_prod", 32'(product), 32'd0);
      for (int k = 1; k <= WIDTH + 1; k++) begin
         @(posedge clk);
         #1;
         if (ign_start && k == 2) begin
            start = 1'b1;
            a     = 8'd7;
            b     = 8'd7;
         end else begin
            start = 1'b0;
         end
         if (k <= WIDTH) begin
            part = int'(av) * (int'(bv) % (1 << k));
            check("calc_prod", 32'(product), part);
            check("calc_done", 32'(done), 32'd0);
            check("calc_busy", 32'(busy), 32'd1);
         end else begin
            check("fin_prod", 32'(product), full);
            check("fin_done", 32'(done), 32'd1);
            check("fin_busy", 32'(busy), 32'd0);
            check("ds_reg", 32'(ds_reg), full);
         end
      end
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      check("rst_prod", 32'(product), 32'd0);
      check("rst_done", 32'(done), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      run_mul(8'd13, 8'd11, 1'b0);
      check("ex_13x11", 32'(product), 32'h008F);
      @(negedge clk);
      run_mul(8'd255, 8'd255, 1'b0);
      check("ex_255x255", 32'(product), 32'hFE01);
      @(negedge clk);
      run_mul(8'd0, 8'd200, 1'b0);
      check("ex_0x200", 32'(product), 32'h0000);
      @(negedge clk);
      run_mul(8'd3, 8'd5, 1'b1);
      check("ex_ignored", 32'(product), 32'h000F);
      // Back-to-back: started on the edge right after done rose.
      run_mul(8'd2, 8'd128, 1'b0);
      check("ex_b2b", 32'(product), 32'h0100);

      // Hold in DONE without start.
      repeat (3) @(posedge clk);
      #1;
      check("hold_prod", 32'(product), 32'h0100);
      check("hold_done", 32'(done), 32'd1);

      // Asynchronous reset between edges, mid-CALC.
      @(negedge clk);
      a     = 8'd99;
      b     = 8'd77;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("arst_prod", 32'(product), 32'd0);
      check("arst_done", 32'(done), 32'd1);
      check("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_mul(8'd6, 8'd7, 1'b0);
      check("ex_6x7", 32'(product), 32'h002A);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         run_mul(WIDTH'($urandom), WIDTH'($urandom), (($urandom % 4) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
